// File: rtl/rotor_return_unit.sv
// Return-path rotor stage: passes the reflected letter back through rotor2,
// rotor1, rotor0 using inverse wirings, one rotor per clock, start/done handshake.
module rotor_return_unit #(
    parameter int         ALPHA    = 26,
    parameter logic [4:0] ERR_CODE = 5'd31
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] data_in,
    input  logic [4:0] pos0,
    input  logic [4:0] pos1,
    input  logic [4:0] pos2,
    output logic [4:0] data_out,
    output logic       done_out,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, S2, S1, S0} state_t;

    localparam logic [5:0] ALPHA6 = 6'(ALPHA);
    localparam logic [4:0] MAX_LETTER = 5'(ALPHA - 1);

    state_t     state;
    logic [4:0] x_reg, p0_reg, p1_reg, p2_reg;
    logic       bad_reg;

    logic [4:0] pos_sel, s_idx, y_val, next_x;

    // A single subtraction suffices: valid operands never reach 2*ALPHA.
    function automatic logic [4:0] mod_alpha(input logic [5:0] v);
        return (v >= ALPHA6) ? 5'(v - ALPHA6) : v[4:0];
    endfunction

    function automatic logic [4:0] inv2(input logic [4:0] s);
        case (s)
            5'd0: return 5'd19;   5'd1: return 5'd0;    5'd2: return 5'd6;
            5'd3: return 5'd1;    5'd4: return 5'd15;   5'd5: return 5'd2;
            5'd6: return 5'd18;   5'd7: return 5'd3;    5'd8: return 5'd16;
            5'd9: return 5'd4;    5'd10: return 5'd20;  5'd11: return 5'd5;
            5'd12: return 5'd21;  5'd13: return 5'd13;  5'd14: return 5'd25;
            5'd15: return 5'd7;   5'd16: return 5'd24;  5'd17: return 5'd8;
            5'd18: return 5'd23;  5'd19: return 5'd9;   5'd20: return 5'd22;
            5'd21: return 5'd11;  5'd22: return 5'd17;  5'd23: return 5'd10;
            5'd24: return 5'd14;  5'd25: return 5'd12;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] inv1(input logic [4:0] s);
        case (s)
            5'd0: return 5'd0;    5'd1: return 5'd9;    5'd2: return 5'd15;
            5'd3: return 5'd2;    5'd4: return 5'd25;   5'd5: return 5'd22;
            5'd6: return 5'd17;   5'd7: return 5'd11;   5'd8: return 5'd5;
            5'd9: return 5'd1;    5'd10: return 5'd3;   5'd11: return 5'd10;
            5'd12: return 5'd14;  5'd13: return 5'd19;  5'd14: return 5'd24;
            5'd15: return 5'd20;  5'd16: return 5'd16;  5'd17: return 5'd6;
            5'd18: return 5'd4;   5'd19: return 5'd13;  5'd20: return 5'd7;
            5'd21: return 5'd23;  5'd22: return 5'd12;  5'd23: return 5'd8;
            5'd24: return 5'd21;  5'd25: return 5'd18;
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [4:0] inv0(input logic [4:0] s);
        case (s)
            5'd0: return 5'd20;   5'd1: return 5'd22;   5'd2: return 5'd24;
            5'd3: return 5'd6;    5'd4: return 5'd0;    5'd5: return 5'd3;
            5'd6: return 5'd5;    5'd7: return 5'd15;   5'd8: return 5'd21;
            5'd9: return 5'd25;   5'd10: return 5'd1;   5'd11: return 5'd4;
            5'd12: return 5'd2;   5'd13: return 5'd10;  5'd14: return 5'd12;
            5'd15: return 5'd19;  5'd16: return 5'd7;   5'd17: return 5'd23;
            5'd18: return 5'd18;  5'd19: return 5'd11;  5'd20: return 5'd17;
            5'd21: return 5'd8;   5'd22: return 5'd13;  5'd23: return 5'd16;
            5'd24: return 5'd14;  5'd25: return 5'd9;
            default: return 5'd0;
        endcase
    endfunction

    // One shared stage datapath; the state picks which rotor it models.
    always_comb begin
        pos_sel = p0_reg;
        y_val   = 5'd0;
        case (state)
            S2:      pos_sel = p2_reg;
            S1:      pos_sel = p1_reg;
            default: pos_sel = p0_reg;
        endcase
        s_idx = mod_alpha({1'b0, x_reg} + {1'b0, pos_sel});
        case (state)
            S2:      y_val = inv2(s_idx);
            S1:      y_val = inv1(s_idx);
            default: y_val = inv0(s_idx);
        endcase
        next_x = mod_alpha({1'b0, y_val} + ALPHA6 - {1'b0, pos_sel});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_reg    <= 5'd0;
            p0_reg   <= 5'd0;
            p1_reg   <= 5'd0;
            p2_reg   <= 5'd0;
            bad_reg  <= 1'b0;
            data_out <= 5'd0;
            done_out <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg   <= data_in;
                        p0_reg  <= pos0;
                        p1_reg  <= pos1;
                        p2_reg  <= pos2;
                        bad_reg <= (data_in > MAX_LETTER) || (pos0 > MAX_LETTER) ||
                                   (pos1 > MAX_LETTER) || (pos2 > MAX_LETTER);
                        busy    <= 1'b1;
                        state   <= S2;
                    end
                end
                S2: begin
                    x_reg <= next_x;
                    state <= S1;
                end
                S1: begin
                    x_reg <= next_x;
                    state <= S0;
                end
                S0: begin
                    data_out <= bad_reg ? ERR_CODE : next_x;
                    err      <= bad_reg;
                    done_out <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_return_unit.sv
// Self-checking bench for rotor_return_unit: directed plan vectors plus random
// requests checked against a string-table reference model of the return path.
module tb_rotor_return_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] data_in, pos0, pos1, pos2;
    logic [4:0] data_out;
    logic       done_out, busy, err;

    int vectors = 0;
    int miscompares = 0;

    string tab2 = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
    string tab1 = "AJPCZWRLFBDKOTYUQGENHXMIVS";
    string tab0 = "UWYGADFPVZBECKMTHXSLRINQOJ";

    rotor_return_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .pos0(pos0), .pos1(pos1), .pos2(pos2), .data_out(data_out),
        .done_out(done_out), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: reverse pass through rotor III, II, I using the letter strings.
    function automatic void model(input int d, input int p0, input int p1, input int p2,
                                  output int res, output bit e);
        int x, s;
        if (d > 25 || p0 > 25 || p1 > 25 || p2 > 25) begin
            res = 31;
            e   = 1'b1;
            return;
        end
        x = d;
        s = (x + p2) % 26;  x = (int'(tab2[s]) - 65 - p2 + 26) % 26;
        s = (x + p1) % 26;  x = (int'(tab1[s]) - 65 - p1 + 26) % 26;
        s = (x + p0) % 26;  x = (int'(tab0[s]) - 65 - p0 + 26) % 26;
        res = x;
        e   = 1'b0;
    endfunction

    // Issues one request, scrambles inputs once it is captured, waits for done.
    task automatic send_and_wait(input logic [4:0] d, input logic [4:0] a0,
                                 input logic [4:0] a1, input logic [4:0] a2,
                                 output int lat, output logic [4:0] res,
                                 output logic e, output int busy_cycles);
        lat = -1;
        res = 5'd0;
        e = 1'b0;
        busy_cycles = 0;
        @(negedge clk);
        data_in = d; pos0 = a0; pos1 = a1; pos2 = a2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        data_in = 5'($urandom); pos0 = 5'($urandom);
        pos1 = 5'($urandom); pos2 = 5'($urandom);
        if (busy) busy_cycles++;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cycles++;
            if (done_out) begin
                lat = k;
                res = data_out;
                e = err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 1'b0;
        data_in = 5'd0; pos0 = 5'd0; pos1 = 5'd0; pos2 = 5'd0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({data_out, done_out, busy, err} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%0d done=%b busy=%b err=%b, want all zero",
                     data_out, done_out, busy, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic directed(input string name, input int d, input int a0, input int a1,
                            input int a2);
        int lat, bc, exp_res;
        bit exp_e;
        logic [4:0] res;
        logic e;
        model(d, a0, a1, a2, exp_res, exp_e);
        send_and_wait(5'(d), 5'(a0), 5'(a1), 5'(a2), lat, res, e, bc);
        vectors++;
        if (lat !== 3) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles, want 3", name, lat);
        end
        vectors++;
        if (res !== 5'(exp_res)) begin
            miscompares++;
            $display("FAIL %s_data: got %0d, want %0d", name, res, exp_res);
        end
        vectors++;
        if (e !== exp_e) begin
            miscompares++;
            $display("FAIL %s_err: got %b, want %b", name, e, exp_e);
        end
        vectors++;
        if (bc !== 3) begin
            miscompares++;
            $display("FAIL %s_busy_len: got %0d cycles, want 3", name, bc);
        end
    endtask

    task automatic test_directed();
        int r;
        bit e;
        model(0, 0, 0, 0, r, e);
        vectors++;
        if (r !== 10) begin
            miscompares++;
            $display("FAIL model_sanity: got %0d, want 10", r);
        end
        directed("basic", 0, 0, 0, 0);
        directed("wrap_rotor2", 25, 0, 0, 1);
        directed("wrap_rotor0", 0, 25, 0, 0);
        directed("invalid_data", 26, 0, 0, 0);
        directed("after_invalid", 0, 0, 0, 0);
        directed("invalid_pos1", 3, 0, 30, 0);
        directed("max_letter", 25, 25, 25, 25);
    endtask

    task automatic test_random();
        int d, a0, a1, a2, exp_res, lat, bc;
        bit exp_e;
        logic [4:0] res;
        logic e;
        for (int i = 0; i < 30; i++) begin
            d  = $urandom_range(0, 25);
            a0 = $urandom_range(0, 25);
            a1 = $urandom_range(0, 25);
            a2 = $urandom_range(0, 25);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: d  = $urandom_range(26, 31);
                    1: a0 = $urandom_range(26, 31);
                    2: a1 = $urandom_range(26, 31);
                    default: a2 = $urandom_range(26, 31);
                endcase
            end
            model(d, a0, a1, a2, exp_res, exp_e);
            send_and_wait(5'(d), 5'(a0), 5'(a1), 5'(a2), lat, res, e, bc);
            vectors++;
            if (lat !== 3 || res !== 5'(exp_res) || e !== exp_e) begin
                miscompares++;
                $display("FAIL random_%0d: in=%0d p0=%0d p1=%0d p2=%0d got lat=%0d out=%0d err=%b, want lat=3 out=%0d err=%b",
                         i, d, a0, a1, a2, lat, res, e, exp_res, exp_e);
            end
        end
    endtask

    // Start held high: capture in IDLE, three busy cycles, done cycle in IDLE,
    // so done appears at edges 3, 7, 11 after the first capture edge.
    task automatic test_back_to_back();
        @(negedge clk);
        data_in = 5'd0; pos0 = 5'd0; pos1 = 5'd0; pos2 = 5'd0; start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (done_out !== ((k % 4) == 3)) begin
                miscompares++;
                $display("FAIL b2b_done_k%0d: got %b, want %b", k, done_out, (k % 4) == 3);
            end
            if (done_out) begin
                vectors++;
                if (data_out !== 5'd10 || err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_data_k%0d: got %0d err=%b, want 10 err=0", k, data_out, err);
                end
            end
        end
        start = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        int first = -1;
        @(negedge clk);
        data_in = 5'd25; pos0 = 5'd0; pos1 = 5'd0; pos2 = 5'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1; data_in = 5'd7; pos0 = 5'd9;
        for (int k = 2; k <= 10; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done_out) begin
                dones++;
                if (first < 0) first = k;
                vectors++;
                if (data_out !== 5'd0) begin
                    miscompares++;
                    $display("FAIL ignore_start_data: got %0d, want 0", data_out);
                end
            end
        end
        vectors++;
        if (dones !== 1 || first !== 3) begin
            miscompares++;
            $display("FAIL ignore_start_dones: got %0d pulses first at %0d, want 1 at 3", dones, first);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bc, dones = 0;
        logic [4:0] res;
        logic e;
        @(negedge clk);
        data_in = 5'd0; pos0 = 5'd25; pos1 = 5'd0; pos2 = 5'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({data_out, done_out, busy, err} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got out=%0d done=%b busy=%b err=%b, want all zero",
                     data_out, done_out, busy, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done_out) dones++;
        end
        vectors++;
        if (dones !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d pulses, want 0", dones);
        end
        send_and_wait(5'd0, 5'd0, 5'd0, 5'd0, lat, res, e, bc);
        vectors++;
        if (lat !== 3 || res !== 5'd10 || e !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_recover: got lat=%0d out=%0d err=%b, want lat=3 out=10 err=0",
                     lat, res, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
